// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared width and word type for the ripple-carry adder family
package adder_pkg;

  // Default operand width for the base slice of the family
  localparam int ADDER_WIDTH = 2;

  // Operand/sum word at the default width
  typedef logic [ADDER_WIDTH-1:0] adder_word_t;

endpackage : adder_pkg

// File: rtl/full_adder.sv
// rtl/full_adder.sv - single-bit combinational full-adder cell
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  // Propagate term is shared between the sum bit and the carry chain
  logic p;

  assign p    = a ^ b;
  assign s    = p ^ cin;
  assign cout = (a & b) | (cin & p);

endmodule : full_adder

// File: rtl/adder_2bit_rc.sv
// rtl/adder_2bit_rc.sv - registered ripple-carry adder built from full_adder cells
module adder_2bit_rc
  import adder_pkg::*;
#(
  parameter int WIDTH = ADDER_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  // Carry chain: c[0] is tied low since there is no carry-in port
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] sum_d;
  logic             cout_d;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;

  assign c[0] = 1'b0;

  // One cell per bit, each cell's carry feeding the next higher bit
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    full_adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (c[i]),
      .s    (sum_d[i]),
      .cout (c[i+1])
    );
  end

  assign cout_d = c[WIDTH];

  // Output registers: reset clears both, otherwise capture the ripple result
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      sum_q  <= sum_d;
      cout_q <= cout_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;

endmodule : adder_2bit_rc

// File: tb/tb_adder_2bit_rc.sv
// tb/tb_adder_2bit_rc.sv - self-checking bench for the registered ripple-carry adder
module tb_adder_2bit_rc;

  localparam int W = 2;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] sum;
  logic         cout;

  int compared   = 0;
  int mismatched = 0;

  adder_2bit_rc #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .b     (b),
    .sum   (sum),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: result of the most recent edge, in plain integer arithmetic
  function automatic logic [W:0] model(input bit rst_low, input int unsigned x, input int unsigned y);
    int unsigned r;
    if (rst_low) r = 0;
    else         r = x + y;
    return r[W:0];
  endfunction

  task automatic check(input string tag, input logic [W:0] expected);
    logic [W:0] observed;
    observed = {cout, sum};
    compared++;
    assert (observed === expected)
      else begin
        mismatched++;
        $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
  endtask

  // Drive operands/reset, take one edge, then check just after it
  task automatic step(input string tag, input int unsigned x, input int unsigned y, input bit rn);
    a     = x[W-1:0];
    b     = y[W-1:0];
    rst_n = rn;
    @(posedge clk);
    #1;
    check(tag, model(!rn, x, y));
  endtask

  initial begin
    logic [W:0]  held;
    int unsigned ra, rb;
    bit          rr;

    a = '0; b = '0; rst_n = 1'b0;
    @(negedge clk);

    // Reset dominates operand capture for two edges
    step("reset_edge0", 3, 3, 1'b0);
    step("reset_edge1", 3, 3, 1'b0);
    step("release_3p3", 3, 3, 1'b1);

    // Directed arithmetic cases
    step("zero",        0, 0, 1'b1);
    step("nocarry_1p1", 1, 1, 1'b1);
    step("nocarry_2p1", 2, 1, 1'b1);
    step("carry_2p2",   2, 2, 1'b1);
    step("carry_3p3",   3, 3, 1'b1);

    // Mid-cycle operand changes must not show until the next edge
    held = {cout, sum};
    a = 1; b = 0;
    #2;
    check("glitch_hold0", held);
    a = 2; b = 3;
    #2;
    check("glitch_hold1", held);
    @(posedge clk);
    #1;
    check("glitch_last", model(1'b0, 2, 3));

    // Exhaustive pairs with a reset pulse in the middle
    for (int i = 0; i < 16; i++) begin
      step("exhaustive", i / 4, i % 4, !(i == 7 || i == 8));
    end
    step("post_reset_pair", 1, 2, 1'b1);

    // Randomized operands with occasional reset
    for (int n = 0; n < 200; n++) begin
      ra = $urandom_range(0, (1 << W) - 1);
      rb = $urandom_range(0, (1 << W) - 1);
      rr = ($urandom_range(0, 15) != 0);
      step("random", ra, rb, rr);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule : tb_adder_2bit_rc
